// File: rtl/loop_buffer_pkg.sv
// loop_buffer_pkg: opcode constants, controller states and a control-flow opcode helper
package loop_buffer_pkg;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  typedef enum logic [2:0] {TRACK, TRAIN, FILL, PRIME, REUSE} lb_state_e;
  function automatic logic is_ctrl(input logic [6:0] op);
    return op == OP_BRANCH || op == OP_JAL || op == OP_JALR;
  endfunction
endpackage

// File: rtl/loop_buffer_mem.sv
// loop_buffer_mem: DEPTH x 32 instruction store, one write port, one registered read port
module loop_buffer_mem #(
  parameter int DEPTH = 16,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic          clk_i,
  input  logic          reset_ni,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [31:0]   wdata_i,
  input  logic          re_i,
  input  logic [AW-1:0] raddr_i,
  output logic [31:0]   rdata_o
);
  logic [31:0] mem_q [DEPTH];
  // store the captured body; contents are meaningless until a capture completes
  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end
  // read register doubles as the replayed-instruction output, so it clears on reset
  always_ff @(posedge clk_i) begin
    if (!reset_ni) rdata_o <= '0;
    else if (re_i) rdata_o <= mem_q[raddr_i];
  end
endmodule

// File: rtl/loop_buffer.sv
// loop_buffer: detects a short backward loop, captures its body and replays it into decode
module loop_buffer
  import loop_buffer_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int DEPTH = 16,
  parameter int TRAIN_COUNT = 2,
  localparam int IW = $clog2(DEPTH),
  localparam int LW = IW + 1,
  localparam int CW = $clog2(TRAIN_COUNT + 1)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            fetch_valid,
  input  logic [XLEN-1:0] fetch_pc,
  input  logic [31:0]     fetch_instr,
  input  logic [XLEN-1:0] branch_imm,
  input  logic            stall,
  input  logic            mispredict,
  output logic            lb_active,
  output logic            lb_valid,
  output logic [31:0]     lb_instr,
  output logic [XLEN-1:0] lb_pc,
  output logic            flush,
  output logic [XLEN-1:0] resume_pc,
  output logic [LW-1:0]   loop_len
);
  localparam logic [XLEN-1:0] MIN_IMM = XLEN'(-4 * (DEPTH - 1));
  lb_state_e       state_q;
  logic [XLEN-1:0] tag_pc_q, tgt_q, exp_pc_q, neg_imm;
  logic [LW-1:0]   len_q, len_c;
  logic [CW-1:0]   cnt_q;
  logic [IW-1:0]   wr_idx_q, rd_idx_q, rd_idx_d, raddr;
  logic [6:0]      op;
  logic            ctrl, cand, at_tag, we, re;
  assign op       = fetch_instr[6:0];
  assign ctrl     = is_ctrl(op);
  assign neg_imm  = -branch_imm;
  assign cand     = fetch_valid && (op == OP_BRANCH || op == OP_JAL) && $signed(branch_imm) < 0 &&
                    branch_imm[1:0] == 2'b00 && $signed(branch_imm) >= $signed(MIN_IMM);
  assign len_c    = LW'(neg_imm[IW+1:2]) + LW'(1);
  assign at_tag   = fetch_pc == tag_pc_q;
  assign rd_idx_d = (LW'(rd_idx_q) == len_q - LW'(1)) ? '0 : rd_idx_q + IW'(1);
  assign we       = state_q == FILL && fetch_valid && !mispredict && fetch_pc == exp_pc_q && !(ctrl && !at_tag);
  assign re       = state_q == PRIME || (state_q == REUSE && !stall && !mispredict);
  assign raddr    = state_q == PRIME ? '0 : rd_idx_d;
  loop_buffer_mem #(.DEPTH(DEPTH)) u_mem (
    .clk_i   (clk),
    .reset_ni(reset),
    .we_i    (we),
    .waddr_i (wr_idx_q),
    .wdata_i (fetch_instr),
    .re_i    (re),
    .raddr_i (raddr),
    .rdata_o (lb_instr)
  );
  // controller: train on a repeated backward branch, fill the body, then replay until mispredict
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= TRACK;
      tag_pc_q  <= '0;
      tgt_q     <= '0;
      exp_pc_q  <= '0;
      len_q     <= '0;
      cnt_q     <= '0;
      wr_idx_q  <= '0;
      rd_idx_q  <= '0;
      lb_active <= 1'b0;
      lb_valid  <= 1'b0;
      lb_pc     <= '0;
      flush     <= 1'b0;
      resume_pc <= '0;
      loop_len  <= '0;
    end else begin
      flush <= 1'b0;
      if (mispredict && state_q != TRACK) begin
        state_q   <= TRACK;
        lb_active <= 1'b0;
        lb_valid  <= 1'b0;
        loop_len  <= '0;
        flush     <= state_q == REUSE;
        resume_pc <= state_q == REUSE ? tag_pc_q + XLEN'(4) : resume_pc;
      end else begin
        case (state_q)
          TRACK: if (cand) begin
            tag_pc_q <= fetch_pc;
            tgt_q    <= fetch_pc + branch_imm;
            exp_pc_q <= fetch_pc + branch_imm;
            len_q    <= len_c;
            cnt_q    <= CW'(1);
            wr_idx_q <= '0;
            state_q  <= TRAIN_COUNT == 1 ? FILL : TRAIN;
          end
          TRAIN: if (fetch_valid) begin
            if (at_tag && cand) begin
              cnt_q <= cnt_q + CW'(1);
              if (cnt_q + CW'(1) == CW'(TRAIN_COUNT)) state_q <= FILL;
            end else if (fetch_pc < tgt_q || fetch_pc > tag_pc_q || (ctrl && !at_tag)) begin
              state_q <= TRACK;
            end
          end
          FILL: if (fetch_valid) begin
            if (!we) begin
              state_q <= TRACK;
            end else begin
              wr_idx_q <= wr_idx_q + IW'(1);
              exp_pc_q <= exp_pc_q + XLEN'(4);
              if (at_tag) begin
                state_q   <= PRIME;
                loop_len  <= len_q;
                lb_active <= 1'b1;
              end
            end
          end
          PRIME: begin
            state_q  <= REUSE;
            rd_idx_q <= '0;
            lb_valid <= 1'b1;
            lb_pc    <= tgt_q;
          end
          REUSE: if (!stall) begin
            rd_idx_q <= rd_idx_d;
            lb_pc    <= tgt_q + XLEN'({rd_idx_d, 2'b00});
          end
          default: state_q <= TRACK;
        endcase
      end
    end
  end
endmodule

// File: doc/loop_buffer.md
# loop_buffer

Parametrised loop buffer controller for the RISC-V fetch path, with integrated instruction storage. It detects short backward branches/JALs, trains on repeated taken iterations, and captures one basic-block loop body into a DEPTH-entry buffer. It then replays that body into decode with fetch gated off, and on the exit mispredict it flushes and redirects to the fall-through PC. It sits between IF and ID, beside the branch unit that supplies `mispredict`.

## Interface
- `XLEN`, 32, PC and immediate width.
- `DEPTH`, 16, maximum loop body in instructions, including the closing branch; power of two, ≥4.
- `TRAIN_COUNT`, 2, number of consecutive taken observations of the same branch PC required before capture; ≥1.
- `clk`  in  1  clock.
- `reset`  in  1  active-low reset, synchronous to `clk`.
- `fetch_valid`  in  1  `fetch_pc`/`fetch_instr`/`branch_imm` valid this cycle.
- `fetch_pc`  in  XLEN  PC of fetched instruction.
- `fetch_instr`  in  32  fetched instruction.
- `branch_imm`  in  XLEN  sign-extended B/J immediate of `fetch_instr`.
- `stall`  in  1  ID/EX bubble; freezes replay.
- `mispredict`  in  1  branch unit redirect.
- `lb_active`  out  1  buffer owns fetch; IF must block.
- `lb_valid`  out  1  `lb_instr`/`lb_pc` valid.
- `lb_instr`  out  32  replayed instruction.
- `lb_pc`  out  XLEN  PC of replayed instruction.
- `flush`  out  1  one-cycle pipeline flush pulse.
- `resume_pc`  out  XLEN  fetch restart PC, valid with `flush`.
- `loop_len`  out  $clog2(DEPTH)+1  captured body length; 0 when none.

## Operation
- Opcodes: BRANCH 1100011, JAL 1101111, JALR 1100111.
- Candidate: `fetch_valid` & opcode ∈ {BRANCH, JAL} & `branch_imm` signed < 0 & `branch_imm[1:0]`==0 & `branch_imm` ≥ −4·(DEPTH−1). `len` = 1 + (−`branch_imm`)>>2, range 2..DEPTH. Signed XLEN compare throughout.
- States: TRACK, TRAIN, FILL, PRIME, REUSE.
- TRACK: on a candidate, latch `tag_pc`=`fetch_pc`, `tgt`=`fetch_pc`+`branch_imm`, and `len`; `cnt`=1. Go to FILL if TRAIN_COUNT==1, else TRAIN.
- TRAIN: on `fetch_valid`:
  - `fetch_pc`==`tag_pc` and still a candidate: `cnt`++; on reaching TRAIN_COUNT, go to FILL with `exp_pc`=`tgt`, `wr_idx`=0.
  - `fetch_pc` outside [`tgt`, `tag_pc`], or BRANCH/JAL/JALR at PC≠`tag_pc`: go to TRACK.
- FILL: on `fetch_valid`:
  - `fetch_pc`≠`exp_pc`: abort to TRACK.
  - BRANCH/JAL/JALR at PC≠`tag_pc`: abort to TRACK (not a basic block).
  - Otherwise write `mem[wr_idx]`, `wr_idx`++, `exp_pc`+=4.
  - Writing PC==`tag_pc`: go to PRIME, set `loop_len`=`len`.
  - `fetch_valid`=0 cycles hold everything.
- PRIME: `lb_active`=1, `lb_valid`=0, read `mem[0]` issued; `rd_idx`=0; go to REUSE next cycle.
- REUSE: `lb_active`=1, `lb_valid`=1, `lb_pc`=`tgt`+4·`rd_idx`.
  - If `stall`=0, `rd_idx` advances, wrapping `len`−1→0.
  - If `stall`=1, outputs hold.
  - `fetch_*` inputs ignored.
- `mispredict`:
  - In TRAIN/FILL/PRIME: go to TRACK, no flush, `loop_len`=0.
  - In REUSE: `flush`=1 for exactly one cycle, `resume_pc`=`tag_pc`+4, `loop_len`=0, go to TRACK.
  - Priority over wrap, stall, and any transition.
- TRACK ignores `mispredict`.

## Timing
- All outputs registered.
- Reset values: `lb_active`=0, `lb_valid`=0, `lb_instr`=0, `lb_pc`=0, `flush`=0, `resume_pc`=0, `loop_len`=0. State TRACK; all indices and counters 0.
- Reset asserted mid-REUSE: all outputs are 0 after the next edge, with no flush pulse.
- Memory: synchronous write, one-cycle synchronous read.
- Capture latency: the cycle after the `tag_pc` write, state is PRIME. The following cycle, first `lb_valid`=1 with `lb_pc`=`tgt`.
- Replay: one instruction per non-stalled cycle; no bubble at wrap.
- `flush` asserts the cycle after `mispredict` is sampled; `lb_active`=0 that same cycle.

## Structure
- `loop_buffer_pkg`: opcode constants and the state enum.
- `loop_buffer_mem` sub-module: DEPTH×32, one write port, one registered read port.

## Test plan
- **Capture and replay.** DEPTH=16, TRAIN_COUNT=2. Loop 0x100–0x10C, branch at 0x10C with imm=−12, fetched 3 passes. Required: PRIME one cycle, then `lb_pc` 0x100, 0x104, 0x108, 0x10C, 0x100… with matching instructions; `loop_len`=4.
- **Too far.** imm=−64 at DEPTH=16. Required: stays TRACK; `lb_active` never asserts.
- **Non-basic-block body.** BRANCH at 0x104 during FILL. Required: return to TRACK, `lb_active`=0. A later clean loop still captures.
- **Stall.** `stall`=1 for 3 cycles at `lb_pc`=0x108. Required: `lb_pc`/`lb_instr` held 3 cycles, then 0x10C.
- **Exit.** `mispredict` during REUSE. Required: `flush`=1 for one cycle, `resume_pc`=0x110, `lb_active`=0 and `loop_len`=0 that cycle. `mispredict` coincident with wrap: same result.
- **Reset.** `reset`=0 mid-REUSE. Required: all outputs 0 after the next edge, no flush. TRAIN_COUNT=1 variant: capture after the first taken pass.
